// File: rtl/board_controller.sv
// board_controller: synchronises and debounces the paddle buttons, detects one
// frame tick per VGA frame and moves the board once per frame with an
// accelerating speed, clamped to the visible area.
// Optional build macro BOARD_WRAP_EN: the board wraps around the display edges
// instead of clamping, and at_edge is held at 0.
module board_controller #(
  parameter int unsigned X_MAX           = 639,
  parameter int unsigned BOARD_WIDTH     = 64,
  parameter int unsigned BOARD_Y         = 440,
  parameter int unsigned INIT_X          = 288,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MIN_SPEED       = 1,
  parameter int unsigned MAX_SPEED       = 8,
  parameter int unsigned ACCEL_FRAMES    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] board_x,
  output logic [9:0] board_y,
  output logic       moving,
  output logic       at_edge
);

  localparam int unsigned X_LIM = X_MAX - BOARD_WIDTH + 1;
  localparam int unsigned POS_W = 11;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SPD_W = $clog2(MAX_SPEED + 1);
  localparam int unsigned FC_W  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  // Index 0 = left button, index 1 = right button
  logic [1:0]      sync1, sync2;
  logic [1:0]      stable;
  logic [DB_W-1:0] db_cnt [2];

  logic             cond_d;
  logic             cond_c;
  logic             frame_tick_c;
  state_t           state;
  state_t           target_c;
  logic [SPD_W-1:0] speed;
  logic [FC_W-1:0]  frame_cnt;

  logic [POS_W-1:0] pos_c;
  logic [POS_W-1:0] spd_c;
  logic [POS_W-1:0] sum_c;
  logic [POS_W-1:0] next_x_c;

  // Two-flop synchroniser for the raw asynchronous buttons
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_right, btn_left};
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Frame tick: rising edge of the multi-clock "row 481, column 0" window
  always_comb begin
    cond_c       = (y == 10'd481) && (x == 10'd0);
    frame_tick_c = cond_c & ~cond_d;
  end

  // Target direction depends only on the debounced button pair
  always_comb begin
    target_c = IDLE;
    if (stable[0] && !stable[1]) begin
      target_c = LEFT;
    end else if (stable[1] && !stable[0]) begin
      target_c = RIGHT;
    end
  end

  // Candidate board position for this frame, in 11-bit arithmetic
  always_comb begin
    pos_c    = POS_W'(board_x);
    spd_c    = POS_W'(speed);
    sum_c    = pos_c + spd_c;
    next_x_c = pos_c;
    if (state == RIGHT) begin
`ifdef BOARD_WRAP_EN
      next_x_c = (sum_c > POS_W'(X_LIM)) ? (sum_c - POS_W'(X_LIM + 1)) : sum_c;
`else
      next_x_c = (sum_c > POS_W'(X_LIM)) ? POS_W'(X_LIM) : sum_c;
`endif
    end else if (state == LEFT) begin
`ifdef BOARD_WRAP_EN
      next_x_c = (pos_c < spd_c) ? (pos_c + POS_W'(X_LIM + 1) - spd_c) : (pos_c - spd_c);
`else
      next_x_c = (pos_c < spd_c) ? '0 : (pos_c - spd_c);
`endif
    end
  end

  // Direction FSM, per-frame motion with acceleration, and registered status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      speed     <= SPD_W'(MIN_SPEED);
      frame_cnt <= '0;
      board_x   <= 10'(INIT_X);
      board_y   <= 10'(BOARD_Y);
      moving    <= 1'b0;
      at_edge   <= 1'b0;
      cond_d    <= 1'b0;
    end else begin
      cond_d  <= cond_c;
      board_y <= 10'(BOARD_Y);
      moving  <= (state != IDLE);
`ifdef BOARD_WRAP_EN
      at_edge <= 1'b0;
`else
      at_edge <= (board_x == 10'd0) || (board_x == 10'(X_LIM));
`endif
      if (target_c != state) begin
        // A direction change restarts the ramp and suppresses this cycle's move
        state     <= target_c;
        speed     <= SPD_W'(MIN_SPEED);
        frame_cnt <= '0;
      end else if (frame_tick_c && (state != IDLE)) begin
        board_x <= 10'(next_x_c);
        if (frame_cnt == FC_W'(ACCEL_FRAMES - 1)) begin
          frame_cnt <= '0;
          if (speed < SPD_W'(MAX_SPEED)) begin
            speed <= speed + SPD_W'(1);
          end
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_board_controller.sv
// Testbench for board_controller: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_board_controller;

  localparam int DB   = 16;
  localparam int XL   = 576;
  localparam int BY   = 440;
  localparam int IX   = 288;
  localparam int VMAX = 8;
  localparam int AF   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic [9:0] x = 10'd1;
  logic [9:0] y = 10'd0;
  logic [9:0] board_x;
  logic [9:0] board_y;
  logic       moving;
  logic       at_edge;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  board_controller #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk       (clk),
    .reset_n   (rst_n),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .x         (x),
    .y         (y),
    .board_x   (board_x),
    .board_y   (board_y),
    .moving    (moving),
    .at_edge   (at_edge)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: direction from button levels, position as plain integers
  int m_x = IX, m_dir = 0, m_spd = 1, m_frames = 0;
  int m_moving = 0, m_edge = 0;
  int m_want, l_run = 0, r_run = 0;
  bit l_q0 = 0, l_q1 = 0, r_q0 = 0, r_q1 = 0, l_st = 0, r_st = 0;
  bit m_prev_cond = 0, m_cond, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x = IX; m_dir = 0; m_spd = 1; m_frames = 0;
      m_moving = 0; m_edge = 0; l_run = 0; r_run = 0;
      l_q0 = 0; l_q1 = 0; r_q0 = 0; r_q1 = 0; l_st = 0; r_st = 0;
      m_prev_cond = 0;
    end else begin
      m_cond = (y == 10'd481) && (x == 10'd0);
      m_tick = m_cond && !m_prev_cond;
      m_prev_cond = m_cond;
      m_moving = (m_dir != 0) ? 1 : 0;
`ifdef BOARD_WRAP_EN
      m_edge = 0;
`else
      m_edge = (m_x == 0 || m_x == XL) ? 1 : 0;
`endif
      m_want = (l_st && !r_st) ? -1 : ((r_st && !l_st) ? 1 : 0);
      if (m_want != m_dir) begin
        m_dir = m_want; m_spd = 1; m_frames = 0;
      end else if (m_tick && m_dir != 0) begin
        m_x = m_x + m_dir * m_spd;
`ifdef BOARD_WRAP_EN
        if (m_x < 0) m_x = m_x + XL + 1;
        if (m_x > XL) m_x = m_x - (XL + 1);
`else
        if (m_x < 0) m_x = 0;
        if (m_x > XL) m_x = XL;
`endif
        m_frames++;
        if (m_frames == AF) begin
          m_frames = 0;
          if (m_spd < VMAX) m_spd++;
        end
      end
      // A synchronised level is adopted once it has disagreed for DB straight clocks
      if (l_q1 != l_st) begin
        l_run++;
        if (l_run == DB) begin l_st = l_q1; l_run = 0; end
      end else l_run = 0;
      if (r_q1 != r_st) begin
        r_run++;
        if (r_run == DB) begin r_st = r_q1; r_run = 0; end
      end else r_run = 0;
      l_q1 = l_q0; l_q0 = btn_left;
      r_q1 = r_q0; r_q0 = btn_right;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_board_x", int'(board_x), m_x);
      check("cyc_board_y", int'(board_y), BY);
      check("cyc_moving", int'(moving), m_moving);
      check("cyc_at_edge", int'(at_edge), m_edge);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: the tick condition lasts 4 clocks, then 4 idle clocks
  task automatic frame();
    y = 10'd481; x = 10'd0;
    cycles(4);
    x = 10'd1; y = 10'd0;
    cycles(4);
  endtask

  int ramp_exp [8] = '{289, 290, 291, 292, 294, 296, 298, 300};
  int burst = 0;

  initial begin
    cycles(3);
    check("rst_board_x", int'(board_x), IX);
    check("rst_board_y", int'(board_y), BY);
    check("rst_moving", int'(moving), 0);
    check("rst_at_edge", int'(at_edge), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Hold right: speed ramps after every fourth tick
    btn_right = 1'b1;
    cycles(DB + 6);
    for (int i = 0; i < 8; i++) begin
      frame();
      check("ramp_x", int'(board_x), ramp_exp[i]);
      check("ramp_moving", int'(moving), 1);
    end

    // Asynchronous reset mid-move
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_x", int'(board_x), IX);
    check("async_y", int'(board_y), BY);
    check("async_moving", int'(moving), 0);
    btn_right = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Short glitch on left is rejected
    btn_left = 1'b1;
    cycles(10);
    btn_left = 1'b0;
    cycles(DB + 6);
    frame();
    check("glitch_x", int'(board_x), IX);
    check("glitch_moving", int'(moving), 0);

`ifndef BOARD_WRAP_EN
    // Hold left until clamped at column 0
    btn_left = 1'b1;
    cycles(DB + 6);
    for (int i = 0; i < 100 && board_x != 10'd0; i++) frame();
    check("clamp_x", int'(board_x), 0);
    check("clamp_edge", int'(at_edge), 1);
    repeat (3) frame();
    check("clamp_hold_x", int'(board_x), 0);

    // Right from 0, then both held freezes, then release right -> left at speed 1
    btn_left = 1'b0;
    btn_right = 1'b1;
    cycles(DB + 6);
    repeat (5) frame();
    check("right_from0_x", int'(board_x), 6);
    btn_left = 1'b1;
    cycles(DB + 6);
    repeat (3) frame();
    check("both_frozen_x", int'(board_x), 6);
    check("both_moving", int'(moving), 0);
    btn_right = 1'b0;
    cycles(DB + 6);
    frame();
    check("left_resume_x", int'(board_x), 5);
    check("left_resume_moving", int'(moving), 1);
`endif

    // Randomized buttons and tick windows
    btn_left = 1'b0;
    btn_right = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 19) == 0) btn_right = ~btn_right;
      if (burst > 0) begin
        x = 10'd0; y = 10'd481; burst--;
      end else if ($urandom_range(0, 11) == 0) begin
        x = 10'd0; y = 10'd481; burst = $urandom_range(0, 4);
      end else begin
        x = 10'($urandom_range(1, 799));
        y = 10'($urandom_range(0, 524));
      end
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
